// File: rtl/writeback_stage.sv
// Writeback stage: W pipeline register, RUN/HALT/ERR status FSM and gated register-file write ports.
// Optional retired-instruction counter and retired_cnt_o port are built when RETIRE_CNT_EN is defined.
module writeback_stage (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        W_stall_i,
  input  logic        W_bubble_i,
  input  logic [2:0]  m_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [3:0]  M_dstE_i,
  input  logic [3:0]  M_dstM_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] m_valM_i,
  output logic [3:0]  W_dstE_o,
  output logic [3:0]  W_dstM_o,
  output logic [63:0] W_valE_o,
  output logic [63:0] W_valM_o,
  output logic [3:0]  W_icode_o,
  output logic [2:0]  W_stat_o,
  output logic [2:0]  Stat_o,
  output logic        halted_o
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt_o
`endif
);

  localparam int          DATA_W    = 64;
  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_HLT  = 3'd2;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [2:0]  STAT_INS  = 3'd4;
  localparam logic [3:0]  REG_NONE  = 4'hF;
  localparam logic [3:0]  ICODE_NOP = 4'h1;

  typedef enum logic [1:0] {RUN, HALT, ERR} state_t;

  state_t                   state, state_nxt;
  logic [2:0]               cause_stat;
  logic [3:0]               w_icode_p1;
  logic [2:0]               w_stat_p1;
  logic [3:0]               w_dste_p1;
  logic [3:0]               w_dstm_p1;
  logic signed [DATA_W-1:0] w_vale_p1;
  logic signed [DATA_W-1:0] w_valm_p1;
  logic                     vld_p1;
  logic                     wr_en;

  // M -> W boundary: frozen by stall or once the processor has stopped
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_icode_p1 <= ICODE_NOP;
      w_stat_p1  <= STAT_AOK;
      w_dste_p1  <= REG_NONE;
      w_dstm_p1  <= REG_NONE;
      w_vale_p1  <= '0;
      w_valm_p1  <= '0;
      vld_p1     <= 1'b0;
    end else if (!W_stall_i && !halted_o) begin
      if (W_bubble_i) begin
        w_icode_p1 <= ICODE_NOP;
        w_stat_p1  <= STAT_AOK;
        w_dste_p1  <= REG_NONE;
        w_dstm_p1  <= REG_NONE;
        w_vale_p1  <= '0;
        w_valm_p1  <= '0;
        vld_p1     <= 1'b0;
      end else begin
        w_icode_p1 <= M_icode_i;
        w_stat_p1  <= m_stat_i;
        w_dste_p1  <= M_dstE_i;
        w_dstm_p1  <= M_dstM_i;
        w_vale_p1  <= M_valE_i;
        w_valm_p1  <= m_valM_i;
        vld_p1     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= RUN;
      cause_stat <= STAT_AOK;
    end else begin
      state <= state_nxt;
      if (state == RUN && state_nxt != RUN) cause_stat <= w_stat_p1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (vld_p1 && w_stat_p1 == STAT_HLT) state_nxt = HALT;
        else if (vld_p1 && (w_stat_p1 == STAT_ADR || w_stat_p1 == STAT_INS)) state_nxt = ERR;
      end
      default: state_nxt = state;
    endcase
  end

  // A pop into the same register writes only valM, so the E port is suppressed
  always_comb begin
    halted_o = (state != RUN);
    Stat_o   = (state == RUN) ? STAT_AOK : cause_stat;
    wr_en    = (state == RUN) && vld_p1 && (w_stat_p1 == STAT_AOK);
    W_dstM_o = wr_en ? w_dstm_p1 : REG_NONE;
    W_dstE_o = (wr_en && w_dste_p1 != w_dstm_p1) ? w_dste_p1 : REG_NONE;
  end

  assign W_valE_o  = w_vale_p1;
  assign W_valM_o  = w_valm_p1;
  assign W_icode_o = w_icode_p1;
  assign W_stat_o  = w_stat_p1;

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) retired_cnt_o <= '0;
    else if (wr_en && !W_stall_i) retired_cnt_o <= retired_cnt_o + 32'd1;
  end
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 clk_i  input  1  single clock; all state updates on posedge clk_i.
REQ-002 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-003 W_stall_i  input  1  hold the W register contents.
REQ-004 W_bubble_i  input  1  load a bubble into the W register.
REQ-005 m_stat_i  input  3  status from memory stage: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-006 M_icode_i  input  4  instruction code from the memory stage.
REQ-007 M_dstE_i / M_dstM_i  input  4 each  destination registers; 4'hF = none.
REQ-008 M_valE_i / m_valM_i  input  64 each  ALU result and memory read data.
REQ-009 W_dstE_o / W_dstM_o  output  4 each  register-file write addresses to decode; 4'hF = no write.
REQ-010 W_valE_o / W_valM_o  output  64 each  register-file write data.
REQ-011 W_icode_o  output  4; W_stat_o  output  3  latched W-stage fields.
REQ-012 Stat_o  output  3  processor status; halted_o  output  1  high in HALT or ERR.
REQ-013 retired_cnt_o  output  32  retired-instruction count; present only with RETIRE_CNT_EN.

Function
REQ-014 The W register SHALL capture icode, stat, dstE, dstM, valE and valM from the M-side inputs each posedge when W_stall_i=0 and W_bubble_i=0.
REQ-015 W_stall_i=1 SHALL hold the W register; W_stall_i has priority over W_bubble_i.
REQ-016 Bubble SHALL load icode=4'h1 (NOP), stat=AOK, dstE=dstM=4'hF, valE=valM=0, and valid=0.
REQ-017 An internal valid bit SHALL be 1 for every captured non-bubble instruction.
REQ-018 The FSM SHALL have three states: RUN, HALT and ERR.
REQ-019 RUN SHALL go to HALT on the posedge after the W register holds valid=1 with stat=HLT.
REQ-020 RUN SHALL go to ERR on the posedge after the W register holds valid=1 with stat=ADR or INS.
REQ-021 HALT and ERR SHALL be terminal until reset.
REQ-022 W_dstE_o and W_dstM_o SHALL be 4'hF whenever the FSM is not RUN, W_stat_o is not AOK, or valid=0.
REQ-023 When W_dstE equals W_dstM (not 4'hF), W_dstE_o SHALL be 4'hF so that only valM is written.
REQ-024 Write outputs SHALL otherwise be the W register fields, combinationally, with no added latency.
REQ-025 Stat_o SHALL be AOK in RUN; in HALT or ERR it SHALL be the stat code that caused the transition, held stable.
REQ-026 Once halted_o=1, W register updates SHALL be ignored.

Reset
REQ-027 While rst_n_i=0 the W register SHALL equal the bubble value and the FSM SHALL be RUN.
REQ-028 While rst_n_i=0, Stat_o SHALL be AOK, halted_o 0, all dst outputs 4'hF and retired_cnt_o 0.
REQ-029 Reset asserted mid-operation, including in HALT or ERR, SHALL take effect immediately and asynchronously.
REQ-030 Release of reset SHALL be sampled on the next posedge clk_i.

Configuration
REQ-031 Macro RETIRE_CNT_EN defined: the retired_cnt_o port and a 32-bit counter SHALL exist.
REQ-032 Counter rule: increment by 1 on each posedge where state=RUN, valid=1, W_stat=AOK and W_stall_i=0; wrap from 32'hFFFFFFFF to 0.
REQ-033 Macro RETIRE_CNT_EN undefined: neither the port nor the counter logic SHALL exist; all other behaviour is unchanged.

Verification
REQ-034 OPq instruction, dstE=3, valE=64'h2A, stat AOK -> next cycle W_dstE_o=3, W_valE_o=64'h2A, W_dstM_o=F.
REQ-035 popq with dstE=dstM=4, valM=64'h55 -> W_dstE_o=F, W_dstM_o=4, W_valM_o=64'h55.
REQ-036 halt (stat=2) enters W -> following cycle halted_o=1, Stat_o=2, dst outputs F; later inputs ignored.
REQ-037 ADR instruction (stat=3) with dstE=1 -> W_dstE_o=F in its W cycle, then Stat_o=3 and halted_o=1.
REQ-038 W_stall_i=1 for 3 cycles with changing inputs -> outputs constant; W_stall_i=1 and W_bubble_i=1 together -> hold.
REQ-039 RETIRE_CNT_EN with 5 AOK instructions, 2 bubbles and a reset in the middle -> counter returns to 0 immediately on reset, then counts only AOK retirements.
